// File: rtl/ddio_bidir_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// ddio_bidir_burst_ctrl_if
// Purpose : bundles the burst-request handshake, the write-data stream and the
//           DDIO atom drive signals of one bidirectional DQ pin group.
// Signals :
//   req_valid / req_ready / req_len          burst request handshake
//   wdata_valid / wdata_ready                write half-beat handshake
//   wdata_h / wdata_l                        rising / falling half-beat data
//   ddio_datain_h / ddio_datain_l / ddio_oe  registered drive into the DDIO atom
// Modports:
//   slave  - the burst controller
//   master - the requester / data source (and observer of the DDIO drive)
// ---------------------------------------------------------------------------
interface ddio_bidir_burst_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [LEN_W-1:0]      req_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata_h;
  logic [DATA_WIDTH-1:0] wdata_l;
  logic [DATA_WIDTH-1:0] ddio_datain_h;
  logic [DATA_WIDTH-1:0] ddio_datain_l;
  logic                  ddio_oe;

  modport slave (
    input  req_valid, req_len, wdata_valid, wdata_h, wdata_l,
    output req_ready, wdata_ready, ddio_datain_h, ddio_datain_l, ddio_oe
  );

  modport master (
    output req_valid, req_len, wdata_valid, wdata_h, wdata_l,
    input  req_ready, wdata_ready, ddio_datain_h, ddio_datain_l, ddio_oe
  );
endinterface

// File: rtl/ddio_bidir_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ddio_bidir_burst_ctrl
// Purpose : sequences write bursts on one DDR bidirectional DQ pin group.
//           A request is accepted in IDLE, then output-enable is driven
//           through preamble, data and postamble, followed by a bus
//           turnaround gap with oe low before the next request is taken.
// Ports   :
//   i_clk        single rising-edge clock
//   i_areset     asynchronous active-high reset
//   bus          ddio_bidir_burst_ctrl_if.slave (request, write data, DDIO drive)
//   o_busy       state is not IDLE
//   o_underrun   one-cycle pulse aligned with a DATA cycle whose beat was missing
//   o_len_err    one-cycle pulse after a zero-length request was accepted
// Optional (macro DDIO_BIDIR_CTRL_STATS_EN):
//   o_stat_bursts     saturating count of entries into DATA
//   o_stat_underruns  saturating count of underrun beats
// ---------------------------------------------------------------------------
module ddio_bidir_burst_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 16,
  parameter int LEN_W          = 5,
  parameter int PREAMBLE_CYC   = 1,
  parameter int POSTAMBLE_CYC  = 1,
  parameter int TURNAROUND_CYC = 2
) (
  input  logic                      i_clk,
  input  logic                      i_areset,
  ddio_bidir_burst_ctrl_if.slave    bus,
  output logic                      o_busy,
  output logic                      o_underrun,
  output logic                      o_len_err
`ifdef DDIO_BIDIR_CTRL_STATS_EN
  ,
  output logic [15:0]               o_stat_bursts,
  output logic [15:0]               o_stat_underruns
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_POST = 3'd3,
    ST_TURN = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  // Phase counter load values are "cycles - 1" so the state exits when it reads 0.
  localparam logic [2:0]       PRE_LOAD  = 3'(PREAMBLE_CYC - 1);
  localparam logic [2:0]       POST_LOAD = 3'(POSTAMBLE_CYC - 1);
  localparam logic [2:0]       TURN_LOAD = 3'(TURNAROUND_CYC - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic [LEN_W-1:0]      w_len_clamped;
  logic [LEN_W-1:0]      r_cnt;
  logic [2:0]            r_phase;
  logic                  r_ddio_oe;
  logic [DATA_WIDTH-1:0] r_datain_h;
  logic [DATA_WIDTH-1:0] r_datain_l;
  logic                  r_underrun;
  logic                  r_len_err;
  logic                  r_busy;
  logic                  w_data_next;

  assign w_len_clamped   = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;
  assign w_data_next     = (w_next == ST_DATA);

  // The DDR bus cannot stall: a beat is taken whenever the next cycle is DATA.
  assign bus.wdata_ready = w_data_next;
  assign bus.req_ready   = (r_state == ST_IDLE);

  assign bus.ddio_oe       = r_ddio_oe;
  assign bus.ddio_datain_h = r_datain_h;
  assign bus.ddio_datain_l = r_datain_l;
  assign o_busy            = r_busy;
  assign o_underrun        = r_underrun;
  assign o_len_err         = r_len_err;

  // State register.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and request acceptance.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          // A zero-length request is consumed but produces no bus activity.
          if (w_len_clamped == LEN_ZERO) begin
            w_next = ST_IDLE;
          end else if (PREAMBLE_CYC != 0) begin
            w_next = ST_PRE;
          end else begin
            w_next = ST_DATA;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (r_phase == 3'd0) begin
          w_next = ST_DATA;
        end else begin
          w_next = ST_PRE;
        end
      end
      ST_DATA: begin
        if (r_cnt == LEN_ONE) begin
          if (POSTAMBLE_CYC != 0) begin
            w_next = ST_POST;
          end else begin
            w_next = ST_TURN;
          end
        end else begin
          w_next = ST_DATA;
        end
      end
      ST_POST: begin
        if (r_phase == 3'd0) begin
          w_next = ST_TURN;
        end else begin
          w_next = ST_POST;
        end
      end
      ST_TURN: begin
        if (r_phase == 3'd0) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_TURN;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Beat counter (loaded at acceptance) and per-state phase counter.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_cnt   <= LEN_ZERO;
      r_phase <= 3'd0;
    end else begin
      if (w_accept && (w_next != ST_IDLE)) begin
        r_cnt <= w_len_clamped;
      end else if ((r_state == ST_DATA) && (r_cnt != LEN_ZERO)) begin
        r_cnt <= r_cnt - LEN_ONE;
      end else begin
        r_cnt <= r_cnt;
      end

      if (w_next != r_state) begin
        case (w_next)
          ST_PRE:  r_phase <= PRE_LOAD;
          ST_POST: r_phase <= POST_LOAD;
          ST_TURN: r_phase <= TURN_LOAD;
          default: r_phase <= 3'd0;
        endcase
      end else if (r_phase != 3'd0) begin
        r_phase <= r_phase - 3'd1;
      end else begin
        r_phase <= r_phase;
      end
    end
  end

  // Registered DDIO drive and status pulses, decoded from the next state.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_ddio_oe  <= 1'b0;
      r_datain_h <= {DATA_WIDTH{1'b0}};
      r_datain_l <= {DATA_WIDTH{1'b0}};
      r_underrun <= 1'b0;
      r_len_err  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ddio_oe  <= (w_next == ST_PRE) || (w_next == ST_DATA) || (w_next == ST_POST);
      // A missing beat is sent as zero; the slot still counts toward len.
      if (w_data_next && bus.wdata_valid) begin
        r_datain_h <= bus.wdata_h;
        r_datain_l <= bus.wdata_l;
      end else begin
        r_datain_h <= {DATA_WIDTH{1'b0}};
        r_datain_l <= {DATA_WIDTH{1'b0}};
      end
      r_underrun <= w_data_next && !bus.wdata_valid;
      r_len_err  <= w_accept && (w_len_clamped == LEN_ZERO);
      r_busy     <= (w_next != ST_IDLE);
    end
  end

`ifdef DDIO_BIDIR_CTRL_STATS_EN
  logic [15:0] r_stat_bursts;
  logic [15:0] r_stat_underruns;

  assign o_stat_bursts    = r_stat_bursts;
  assign o_stat_underruns = r_stat_underruns;

  // Saturating burst and underrun statistics.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_stat_bursts    <= 16'd0;
      r_stat_underruns <= 16'd0;
    end else begin
      if (w_data_next && (r_state != ST_DATA) && (r_stat_bursts != 16'hFFFF)) begin
        r_stat_bursts <= r_stat_bursts + 16'd1;
      end else begin
        r_stat_bursts <= r_stat_bursts;
      end
      if (w_data_next && !bus.wdata_valid && (r_stat_underruns != 16'hFFFF)) begin
        r_stat_underruns <= r_stat_underruns + 16'd1;
      end else begin
        r_stat_underruns <= r_stat_underruns;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ddio_bidir_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddio_bidir_burst_ctrl
// Purpose : directed self-checking bench for ddio_bidir_burst_ctrl.
//           dut  uses the default parameters; dut0 has no preamble/postamble.
// ---------------------------------------------------------------------------
module tb_ddio_bidir_burst_ctrl;

  logic clk;
  logic rst;
  logic busy, underrun, len_err;
  logic busy0, underrun0, len_err0;
  logic [15:0] stat_b, stat_u, stat_b0, stat_u0;

  int n_checks;
  int n_pass;

  ddio_bidir_burst_ctrl_if #(.DATA_WIDTH(8), .LEN_W(5)) bus ();
  ddio_bidir_burst_ctrl_if #(.DATA_WIDTH(8), .LEN_W(5)) bus0 ();

  ddio_bidir_burst_ctrl dut (
    .i_clk      (clk),
    .i_areset   (rst),
    .bus        (bus),
    .o_busy     (busy),
    .o_underrun (underrun),
    .o_len_err  (len_err)
`ifdef DDIO_BIDIR_CTRL_STATS_EN
    ,
    .o_stat_bursts    (stat_b),
    .o_stat_underruns (stat_u)
`endif
  );

  ddio_bidir_burst_ctrl #(.PREAMBLE_CYC(0), .POSTAMBLE_CYC(0)) dut0 (
    .i_clk      (clk),
    .i_areset   (rst),
    .bus        (bus0),
    .o_busy     (busy0),
    .o_underrun (underrun0),
    .o_len_err  (len_err0)
`ifdef DDIO_BIDIR_CTRL_STATS_EN
    ,
    .o_stat_bursts    (stat_b0),
    .o_stat_underruns (stat_u0)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!bus.req_ready && k < 60) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int first_acc, second_acc, n_acc, n_rdy, n_oe;
    logic [7:0] eh, el;

    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_len = 5'd0; bus.wdata_valid = 1'b0;
    bus.wdata_h = 8'd0;   bus.wdata_l = 8'd0;
    bus0.req_valid = 1'b0; bus0.req_len = 5'd0; bus0.wdata_valid = 1'b0;
    bus0.wdata_h = 8'd0;   bus0.wdata_l = 8'd0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_oe",    32'(bus.ddio_oe), 32'd0);
    check_eq("rst_dh",    32'(bus.ddio_datain_h), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_lenerr", 32'(len_err), 32'd0);
    check_eq("rst_rdy",   32'(bus.req_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // ---- nominal burst, len=4 ----
    for (int c = 0; c < 10; c++) begin
      bus.req_valid   = (c == 0);
      bus.req_len     = 5'd4;
      bus.wdata_valid = 1'b1;
      bus.wdata_h     = 8'(8'hA0 + c - 1);
      bus.wdata_l     = 8'(8'hB0 + c - 1);
      @(negedge clk);
      eh = (c >= 2 && c <= 5) ? 8'(8'hA0 + c - 2) : 8'h00;
      el = (c >= 2 && c <= 5) ? 8'(8'hB0 + c - 2) : 8'h00;
      check_eq($sformatf("nom_oe_c%0d", c),  32'(bus.ddio_oe), 32'(c >= 1 && c <= 6));
      check_eq($sformatf("nom_rdy_c%0d", c), 32'(bus.wdata_ready), 32'(c >= 1 && c <= 4));
      check_eq($sformatf("nom_dh_c%0d", c),  32'(bus.ddio_datain_h), 32'(eh));
      check_eq($sformatf("nom_dl_c%0d", c),  32'(bus.ddio_datain_l), 32'(el));
      check_eq($sformatf("nom_reqrdy_c%0d", c), 32'(bus.req_ready), 32'(c == 0 || c == 9));
      check_eq($sformatf("nom_busy_c%0d", c), 32'(busy), 32'(c >= 1 && c <= 8));
      tick();
    end
    bus.req_valid = 1'b0;
    wait_idle("nom_idle");

    // ---- underrun: len=3, beat 2 missing ----
    for (int c = 0; c < 9; c++) begin
      bus.req_valid   = (c == 0);
      bus.req_len     = 5'd3;
      bus.wdata_valid = (c != 2);
      bus.wdata_h     = 8'(8'hC0 + c - 1);
      bus.wdata_l     = 8'(8'hD0 + c - 1);
      @(negedge clk);
      eh = (c == 2 || c == 4) ? 8'(8'hC0 + c - 2) : 8'h00;
      check_eq($sformatf("ur_dh_c%0d", c), 32'(bus.ddio_datain_h), 32'(eh));
      check_eq($sformatf("ur_pulse_c%0d", c), 32'(underrun), 32'(c == 3));
      check_eq($sformatf("ur_rdy_c%0d", c), 32'(bus.wdata_ready), 32'(c >= 1 && c <= 3));
      check_eq($sformatf("ur_oe_c%0d", c), 32'(bus.ddio_oe), 32'(c >= 1 && c <= 5));
      tick();
    end
    bus.wdata_valid = 1'b1;
    wait_idle("ur_idle");
`ifdef DDIO_BIDIR_CTRL_STATS_EN
    check_eq("stat_underruns", 32'(stat_u), 32'd1);
    check_eq("stat_bursts",    32'(stat_b), 32'd2);
`endif

    // ---- zero-length request ----
    for (int c = 0; c < 4; c++) begin
      bus.req_valid = (c == 0);
      bus.req_len   = 5'd0;
      @(negedge clk);
      check_eq($sformatf("l0_err_c%0d", c), 32'(len_err), 32'(c == 1));
      check_eq($sformatf("l0_oe_c%0d", c), 32'(bus.ddio_oe), 32'd0);
      check_eq($sformatf("l0_rdy_c%0d", c), 32'(bus.req_ready), 32'd1);
      check_eq($sformatf("l0_busy_c%0d", c), 32'(busy), 32'd0);
      tick();
    end

    // ---- len=31 clamps to 16 beats ----
    n_rdy = 0;
    n_oe  = 0;
    for (int c = 0; c < 30; c++) begin
      bus.req_valid = (c == 0);
      bus.req_len   = 5'd31;
      @(negedge clk);
      if (bus.wdata_ready) n_rdy++;
      if (bus.ddio_oe) n_oe++;
      tick();
    end
    check_eq("clamp_beats", 32'(n_rdy), 32'd16);
    check_eq("clamp_oe",    32'(n_oe),  32'd18);
    wait_idle("clamp_idle");

    // ---- back-to-back len=1 ----
    first_acc = -1;
    second_acc = -1;
    n_acc = 0;
    bus.req_valid = 1'b1;
    bus.req_len   = 5'd1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        if (n_acc == 0) first_acc = c;
        if (n_acc == 1) second_acc = c;
        n_acc++;
      end
      tick();
    end
    bus.req_valid = 1'b0;
    check_eq("b2b_first",   32'(first_acc), 32'd0);
    check_eq("b2b_spacing", 32'(second_acc - first_acc), 32'd6);
    check_eq("b2b_count",   32'(n_acc), 32'd3);
    wait_idle("b2b_idle");

    // ---- reset mid-DATA ----
    bus.wdata_h = 8'h5A;
    bus.wdata_l = 8'hA5;
    bus.wdata_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.req_valid = (c == 0);
      bus.req_len   = 5'd8;
      tick();
    end
    @(negedge clk);
    check_eq("mid_pre_oe", 32'(bus.ddio_oe), 32'd1);
    check_eq("mid_pre_dh", 32'(bus.ddio_datain_h), 32'h5A);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_oe",   32'(bus.ddio_oe), 32'd0);
    check_eq("mid_rst_dh",   32'(bus.ddio_datain_h), 32'd0);
    check_eq("mid_rst_dl",   32'(bus.ddio_datain_l), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rel_rdy", 32'(bus.req_ready), 32'd1);
    check_eq("mid_rel_oe",  32'(bus.ddio_oe), 32'd0);
`ifdef DDIO_BIDIR_CTRL_STATS_EN
    check_eq("mid_stat_b", 32'(stat_b), 32'd0);
`endif
    tick();

    // ---- no preamble/postamble, len=2 ----
    n_oe = 0;
    for (int c = 0; c < 8; c++) begin
      bus0.req_valid   = (c == 0);
      bus0.req_len     = 5'd2;
      bus0.wdata_valid = 1'b1;
      bus0.wdata_h     = 8'(8'hD0 + c);
      bus0.wdata_l     = 8'(8'hE0 + c);
      @(negedge clk);
      if (bus0.ddio_oe) n_oe++;
      eh = (c == 1 || c == 2) ? 8'(8'hD0 + c - 1) : 8'h00;
      el = (c == 1 || c == 2) ? 8'(8'hE0 + c - 1) : 8'h00;
      check_eq($sformatf("np_rdy_c%0d", c), 32'(bus0.wdata_ready), 32'(c <= 1));
      check_eq($sformatf("np_oe_c%0d", c),  32'(bus0.ddio_oe), 32'(c == 1 || c == 2));
      check_eq($sformatf("np_dh_c%0d", c),  32'(bus0.ddio_datain_h), 32'(eh));
      check_eq($sformatf("np_dl_c%0d", c),  32'(bus0.ddio_datain_l), 32'(el));
      tick();
    end
    check_eq("np_oe_total", 32'(n_oe), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
